axis_i2c_target: RTL

AXIS_I2C_TARGET -- requirements
Module: axis_i2c_target

---
 rtl/axis_i2c_pkg.sv | 17 +
 rtl/axis_if.sv | 9 +
 rtl/i2c_sync_edge.sv | 28 ++
 rtl/axis_i2c_target.sv | 134 +++++++++++++
 4 files changed

// File: rtl/axis_i2c_pkg.sv
// Shared widths and FSM state encoding for the write-only I2C target that
// forwards received bytes onto an AXI-Stream master port.
package axis_i2c_pkg;
  localparam int I2C_ADDR_WIDTH  = 7;
  localparam int I2C_DATA_WIDTH  = 8;
  localparam int AXIS_DATA_WIDTH = 16;
  localparam int CNT_WIDTH       = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    DATA,
    ACK_DATA,
    WAIT_STOP
  } i2c_state_e;
endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream channel: data, valid, ready.
interface axis_if #(parameter int DW = 16) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line plus one history flop
// for edge detection. Resets to 1 so an idle bus shows no edges.
module i2c_sync_edge (
  input  logic clk,
  input  logic arst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/axis_i2c_target.sv
// Write-only I2C target: ACKs its own address, streams each received byte
// out on AXI-Stream, and NACKs (with an overrun pulse) if the slot is full.
module axis_i2c_target
  import axis_i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] OWN_ADDR  = 7'h50,
  parameter bit                        LSB_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   arst,
  input  logic   scl,
  input  logic   sda,
  output logic   sda_oe,
  axis_if.master m_axis,
  output logic   busy,
  output logic   overrun
);
  localparam logic [CNT_WIDTH-1:0] BITS = CNT_WIDTH'(I2C_DATA_WIDTH);

  logic scl_q, scl_r, scl_f;
  logic sda_q, sda_r, sda_f;

  i2c_sync_edge u_scl (.clk(clk), .arst(arst), .din(scl), .q(scl_q), .rise(scl_r), .fall(scl_f));
  i2c_sync_edge u_sda (.clk(clk), .arst(arst), .din(sda), .q(sda_q), .rise(sda_r), .fall(sda_f));

  i2c_state_e                 state, state_n;
  logic [CNT_WIDTH-1:0]       cnt;
  logic [I2C_DATA_WIDTH-1:0]  sh, sh_n;
  logic [AXIS_DATA_WIDTH-1:0] tdata_r;
  logic                       tvalid_r;
  logic start_det, stop_det, slot_free, addr_ok;
  logic shift, cnt_clr, oe_set, oe_clr, ld, ovr;

  assign start_det = sda_f & scl_q;
  assign stop_det  = sda_r & scl_q;
  assign slot_free = ~tvalid_r | m_axis.tready;
  assign sh_n      = LSB_FIRST ? {sda_q, sh[I2C_DATA_WIDTH-1:1]}
                               : {sh[I2C_DATA_WIDTH-2:0], sda_q};
  // Address byte is {addr[6:0], rw}, assembled in the same bit order as data.
  assign addr_ok   = (sh[I2C_DATA_WIDTH-1:1] == OWN_ADDR) && !sh[0];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    shift   = 1'b0;
    cnt_clr = 1'b0;
    oe_set  = 1'b0;
    oe_clr  = 1'b0;
    ld      = 1'b0;
    ovr     = 1'b0;
    if (stop_det) begin
      state_n = IDLE;
      oe_clr  = 1'b1;
      cnt_clr = 1'b1;
    end else if (start_det) begin
      state_n = ADDR;
      oe_clr  = 1'b1;
      cnt_clr = 1'b1;
    end else begin
      case (state)
        ADDR: begin
          if (scl_r && cnt < BITS) shift = 1'b1;
          else if (scl_f && cnt == BITS) begin
            state_n = ACK_ADDR;
            oe_set  = addr_ok;
          end
        end
        ACK_ADDR: begin
          if (scl_f) begin
            oe_clr  = 1'b1;
            cnt_clr = 1'b1;
            state_n = sda_oe ? DATA : WAIT_STOP;
          end
        end
        DATA: begin
          if (scl_r && cnt < BITS) shift = 1'b1;
          else if (scl_f && cnt == BITS) begin
            if (slot_free) begin
              ld      = 1'b1;
              oe_set  = 1'b1;
              state_n = ACK_DATA;
            end else begin
              ovr     = 1'b1;
              state_n = WAIT_STOP;
            end
          end
        end
        ACK_DATA: begin
          if (scl_f) begin
            oe_clr  = 1'b1;
            cnt_clr = 1'b1;
            state_n = DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt      <= '0;
      sh       <= '0;
      sda_oe   <= 1'b0;
      tdata_r  <= '0;
      tvalid_r <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (cnt_clr) cnt <= '0;
      else if (shift) begin
        cnt <= cnt + CNT_WIDTH'(1);
        sh  <= sh_n;
      end
      if (oe_set)      sda_oe <= 1'b1;
      else if (oe_clr) sda_oe <= 1'b0;
      // A load in the same clk as a handshake replaces the accepted byte.
      if (ld) begin
        tdata_r  <= AXIS_DATA_WIDTH'(sh);
        tvalid_r <= 1'b1;
      end else if (m_axis.tready) begin
        tvalid_r <= 1'b0;
      end
      overrun <= ovr;
    end
  end

  assign m_axis.tdata  = tdata_r;
  assign m_axis.tvalid = tvalid_r;
  assign busy          = (state != IDLE);
endmodule
